exmem_stage: RTL and testbench

- Pipeline register between the execute stage and the memory stage.
- Captures the EX results and the control signals that flow onward, and applies stall-hold and bubble-insertion rules.
- Owns the LL/SC reservation bit.
- Generates the memory-stage byte-lane write mask, aligned store data and address-error flag from its registered state.

---
 rtl/exmem_stage.sv | 181 ++++++++++++++++++
 tb/tb_exmem_stage.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/exmem_stage.sv
// EX/MEM pipeline register: captures execute results, applies stall/bubble rules,
// owns the LL/SC reservation and derives store lanes and alignment faults.
module exmem_stage #(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EX_Stall,
    input  logic        EX_Flush,
    input  logic        M_Stall,
    input  logic        LL_Clear,
    input  logic [31:0] EX_ALUResult,
    input  logic [31:0] EX_ReadData2,
    input  logic [4:0]  EX_RtRd,
    input  logic        EX_RegWrite,
    input  logic        EX_MemtoReg,
    input  logic        EX_MemRead,
    input  logic        EX_MemWrite,
    input  logic        EX_MemHalf,
    input  logic        EX_MemByte,
    input  logic        EX_MemSignExtend,
    input  logic        EX_LLSC,
    input  logic        EX_IsBDS,
    input  logic [31:0] EX_RestartPC,
    input  logic        EX_WantRtByMEM,
    input  logic        EX_NeedRtByMEM,
    output logic [31:0] M_ALUResult,
    output logic [31:0] M_RestartPC,
    output logic [4:0]  M_RtRd,
    output logic        M_RegWrite,
    output logic        M_MemtoReg,
    output logic        M_MemRead,
    output logic        M_MemHalf,
    output logic        M_MemByte,
    output logic        M_MemSignExtend,
    output logic        M_LLSC,
    output logic        M_IsBDS,
    output logic        M_WantRtByMEM,
    output logic        M_NeedRtByMEM,
    output logic        M_MemWriteEff,
    output logic [3:0]  M_WriteMask,
    output logic [31:0] M_StoreData,
    output logic        M_AddrErr,
    output logic [31:0] M_SCResult,
    output logic        LLBit
);

    logic [31:0] r_alu_p1;
    logic [31:0] r_restart_pc_p1;
    logic [31:0] r_store_rt_p1;
    logic [4:0]  r_rtrd_p1;
    logic        r_reg_write_p1;
    logic        r_memto_reg_p1;
    logic        r_mem_read_p1;
    logic        r_mem_write_p1;
    logic        r_mem_half_p1;
    logic        r_mem_byte_p1;
    logic        r_mem_sext_p1;
    logic        r_llsc_p1;
    logic        r_is_bds_p1;
    logic        r_want_rt_p1;
    logic        r_need_rt_p1;
    logic        r_llbit;

    logic        w_bubble;
    logic        w_addr_err;
    logic        w_write_eff;
    logic        w_ll_retire;
    logic        w_sc_retire;

    // Byte enables for a store; lane numbering flips with endianness.
    function automatic logic [3:0] lane_mask(input logic [1:0] a, input logic half,
                                             input logic is_byte);
        logic [1:0] idx;
        logic       upper;
        idx   = BIG_ENDIAN ? (2'd3 - a) : a;
        upper = BIG_ENDIAN ? !a[1] : a[1];
        if (is_byte)
            lane_mask = 4'b0001 << idx;
        else if (half)
            lane_mask = upper ? 4'b1100 : 4'b0011;
        else
            lane_mask = 4'b1111;
    endfunction

    function automatic logic [31:0] lane_data(input logic [1:0] a, input logic half,
                                              input logic is_byte, input logic [31:0] rt);
        logic upper;
        upper = BIG_ENDIAN ? !a[1] : a[1];
        if (is_byte)
            lane_data = {4{rt[7:0]}};
        else if (half)
            lane_data = upper ? {rt[15:0], 16'h0000} : {16'h0000, rt[15:0]};
        else
            lane_data = rt;
    endfunction

    assign w_bubble = EX_Stall | EX_Flush;

    // EX -> M stage boundary
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_alu_p1        <= 32'h0;
            r_restart_pc_p1 <= 32'h0;
            r_store_rt_p1   <= 32'h0;
            r_rtrd_p1       <= 5'h0;
            r_reg_write_p1  <= 1'b0;
            r_memto_reg_p1  <= 1'b0;
            r_mem_read_p1   <= 1'b0;
            r_mem_write_p1  <= 1'b0;
            r_mem_half_p1   <= 1'b0;
            r_mem_byte_p1   <= 1'b0;
            r_mem_sext_p1   <= 1'b0;
            r_llsc_p1       <= 1'b0;
            r_is_bds_p1     <= 1'b0;
            r_want_rt_p1    <= 1'b0;
            r_need_rt_p1    <= 1'b0;
        end else if (!M_Stall) begin
            r_alu_p1        <= EX_ALUResult;
            r_restart_pc_p1 <= EX_RestartPC;
            r_store_rt_p1   <= EX_ReadData2;
            r_rtrd_p1       <= EX_RtRd;
            r_memto_reg_p1  <= EX_MemtoReg;
            r_mem_half_p1   <= EX_MemHalf;
            r_mem_byte_p1   <= EX_MemByte;
            r_mem_sext_p1   <= EX_MemSignExtend;
            r_llsc_p1       <= EX_LLSC;
            r_is_bds_p1     <= EX_IsBDS;
            r_reg_write_p1  <= EX_RegWrite    & !w_bubble;
            r_mem_read_p1   <= EX_MemRead     & !w_bubble;
            r_mem_write_p1  <= EX_MemWrite    & !w_bubble;
            r_want_rt_p1    <= EX_WantRtByMEM & !w_bubble;
            r_need_rt_p1    <= EX_NeedRtByMEM & !w_bubble;
        end
    end

    assign w_addr_err = (r_mem_read_p1 | r_mem_write_p1) &
                        ((r_mem_half_p1 & r_alu_p1[0]) |
                         (!r_mem_half_p1 & !r_mem_byte_p1 & (r_alu_p1[1:0] != 2'b00)));

    assign w_write_eff = r_mem_write_p1 & !w_addr_err & (!r_llsc_p1 | r_llbit);
    assign w_ll_retire = r_mem_read_p1 & r_llsc_p1 & !w_addr_err;
    assign w_sc_retire = r_mem_write_p1 & r_llsc_p1;

    // Reservation: an explicit clear beats everything, even during a stall.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            r_llbit <= 1'b0;
        else if (LL_Clear)
            r_llbit <= 1'b0;
        else if (!M_Stall) begin
            if (w_ll_retire)
                r_llbit <= 1'b1;
            else if (w_sc_retire)
                r_llbit <= 1'b0;
        end
    end

    assign M_ALUResult     = r_alu_p1;
    assign M_RestartPC     = r_restart_pc_p1;
    assign M_RtRd          = r_rtrd_p1;
    assign M_RegWrite      = r_reg_write_p1;
    assign M_MemtoReg      = r_memto_reg_p1;
    assign M_MemRead       = r_mem_read_p1;
    assign M_MemHalf       = r_mem_half_p1;
    assign M_MemByte       = r_mem_byte_p1;
    assign M_MemSignExtend = r_mem_sext_p1;
    assign M_LLSC          = r_llsc_p1;
    assign M_IsBDS         = r_is_bds_p1;
    assign M_WantRtByMEM   = r_want_rt_p1;
    assign M_NeedRtByMEM   = r_need_rt_p1;
    assign M_AddrErr       = w_addr_err;
    assign M_MemWriteEff   = w_write_eff;
    assign M_WriteMask     = w_write_eff ?
                             lane_mask(r_alu_p1[1:0], r_mem_half_p1, r_mem_byte_p1) : 4'b0000;
    assign M_StoreData     = lane_data(r_alu_p1[1:0], r_mem_half_p1, r_mem_byte_p1,
                                       r_store_rt_p1);
    assign M_SCResult      = {31'h0, r_llbit};
    assign LLBit           = r_llbit;

endmodule

// File: tb/tb_exmem_stage.sv
// Directed bench for exmem_stage: reset, capture, lanes, stall/flush, LL/SC, alignment.
`timescale 1ns/1ps
module tb_exmem_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic        EX_Stall, EX_Flush, M_Stall, LL_Clear;
    logic [31:0] EX_ALUResult, EX_ReadData2, EX_RestartPC;
    logic [4:0]  EX_RtRd;
    logic        EX_RegWrite, EX_MemtoReg, EX_MemRead, EX_MemWrite, EX_MemHalf, EX_MemByte;
    logic        EX_MemSignExtend, EX_LLSC, EX_IsBDS, EX_WantRtByMEM, EX_NeedRtByMEM;
    logic [31:0] M_ALUResult, M_RestartPC, M_StoreData, M_SCResult;
    logic [4:0]  M_RtRd;
    logic        M_RegWrite, M_MemtoReg, M_MemRead, M_MemHalf, M_MemByte, M_MemSignExtend;
    logic        M_LLSC, M_IsBDS, M_WantRtByMEM, M_NeedRtByMEM, M_MemWriteEff, M_AddrErr, LLBit;
    logic [3:0]  M_WriteMask;

    int tests  = 0;
    int failed = 0;

    exmem_stage #(.BIG_ENDIAN(1'b1)) dut (
        .CLK(CLK), .RST(RST), .EX_Stall(EX_Stall), .EX_Flush(EX_Flush), .M_Stall(M_Stall),
        .LL_Clear(LL_Clear), .EX_ALUResult(EX_ALUResult), .EX_ReadData2(EX_ReadData2),
        .EX_RtRd(EX_RtRd), .EX_RegWrite(EX_RegWrite), .EX_MemtoReg(EX_MemtoReg),
        .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite), .EX_MemHalf(EX_MemHalf),
        .EX_MemByte(EX_MemByte), .EX_MemSignExtend(EX_MemSignExtend), .EX_LLSC(EX_LLSC),
        .EX_IsBDS(EX_IsBDS), .EX_RestartPC(EX_RestartPC), .EX_WantRtByMEM(EX_WantRtByMEM),
        .EX_NeedRtByMEM(EX_NeedRtByMEM), .M_ALUResult(M_ALUResult), .M_RestartPC(M_RestartPC),
        .M_RtRd(M_RtRd), .M_RegWrite(M_RegWrite), .M_MemtoReg(M_MemtoReg),
        .M_MemRead(M_MemRead), .M_MemHalf(M_MemHalf), .M_MemByte(M_MemByte),
        .M_MemSignExtend(M_MemSignExtend), .M_LLSC(M_LLSC), .M_IsBDS(M_IsBDS),
        .M_WantRtByMEM(M_WantRtByMEM), .M_NeedRtByMEM(M_NeedRtByMEM),
        .M_MemWriteEff(M_MemWriteEff), .M_WriteMask(M_WriteMask), .M_StoreData(M_StoreData),
        .M_AddrErr(M_AddrErr), .M_SCResult(M_SCResult), .LLBit(LLBit)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic ex_idle();
        EX_ALUResult = 32'h0; EX_ReadData2 = 32'h0; EX_RestartPC = 32'h0; EX_RtRd = 5'd0;
        EX_RegWrite = 0; EX_MemtoReg = 0; EX_MemRead = 0; EX_MemWrite = 0; EX_MemHalf = 0;
        EX_MemByte = 0; EX_MemSignExtend = 0; EX_LLSC = 0; EX_IsBDS = 0;
        EX_WantRtByMEM = 0; EX_NeedRtByMEM = 0;
    endtask

    task automatic ex_ll(input logic [31:0] addr);
        ex_idle();
        EX_ALUResult = addr; EX_MemRead = 1; EX_LLSC = 1; EX_RegWrite = 1; EX_MemtoReg = 1;
    endtask

    task automatic ex_sc(input logic [31:0] addr, input logic [31:0] rt);
        ex_idle();
        EX_ALUResult = addr; EX_MemWrite = 1; EX_LLSC = 1; EX_RegWrite = 1; EX_ReadData2 = rt;
    endtask

    initial begin
        RST = 1; EX_Stall = 0; EX_Flush = 0; M_Stall = 0; LL_Clear = 0;
        ex_idle();
        step(); step();
        chk("rst_alu", M_ALUResult, 32'h0);
        chk("rst_llbit", {31'h0, LLBit}, 32'h0);
        chk("rst_mask", {28'h0, M_WriteMask}, 32'h0);
        chk("rst_eff", {31'h0, M_MemWriteEff}, 32'h0);
        chk("rst_addrerr", {31'h0, M_AddrErr}, 32'h0);
        RST = 0;

        // Word store
        ex_idle(); EX_ALUResult = 32'h1000_0004; EX_MemWrite = 1; EX_ReadData2 = 32'hDEAD_BEEF;
        EX_RtRd = 5'd5; EX_RestartPC = 32'h0040_0010;
        step();
        chk("sw_mask", {28'h0, M_WriteMask}, 32'hF);
        chk("sw_data", M_StoreData, 32'hDEAD_BEEF);
        chk("sw_eff", {31'h0, M_MemWriteEff}, 32'h1);
        chk("sw_alu", M_ALUResult, 32'h1000_0004);
        chk("sw_pc", M_RestartPC, 32'h0040_0010);
        chk("sw_rtrd", {27'h0, M_RtRd}, 32'd5);

        // Byte store at offset 2
        ex_idle(); EX_ALUResult = 32'h1000_0002; EX_MemWrite = 1; EX_MemByte = 1;
        EX_ReadData2 = 32'h0000_00AB;
        step();
        chk("sb_mask", {28'h0, M_WriteMask}, 32'h2);
        chk("sb_data", M_StoreData, 32'hABAB_ABAB);
        chk("sb_addrerr", {31'h0, M_AddrErr}, 32'h0);

        // Byte store at offset 0 -> leftmost lane
        EX_ALUResult = 32'h1000_0000;
        step();
        chk("sb0_mask", {28'h0, M_WriteMask}, 32'h8);

        // Half store at offset 2
        ex_idle(); EX_ALUResult = 32'h1000_0002; EX_MemWrite = 1; EX_MemHalf = 1;
        EX_ReadData2 = 32'h0000_1234;
        step();
        chk("sh2_mask", {28'h0, M_WriteMask}, 32'h3);
        chk("sh2_data", M_StoreData, 32'h0000_1234);

        // Half store at offset 0
        EX_ALUResult = 32'h1000_0000;
        step();
        chk("sh0_mask", {28'h0, M_WriteMask}, 32'hC);
        chk("sh0_data", M_StoreData, 32'h1234_0000);

        // Stall holds everything while EX changes
        M_Stall = 1;
        for (int i = 0; i < 3; i++) begin
            ex_idle(); EX_ALUResult = 32'h5555_5550 + i; EX_RegWrite = 1;
            step();
            chk("stall_alu", M_ALUResult, 32'h1000_0000);
            chk("stall_mask", {28'h0, M_WriteMask}, 32'hC);
            chk("stall_regwr", {31'h0, M_RegWrite}, 32'h0);
        end

        // Reset asserted mid-stall, between clock edges
        #2; RST = 1; #1;
        chk("rststall_alu", M_ALUResult, 32'h0);
        chk("rststall_mask", {28'h0, M_WriteMask}, 32'h0);
        chk("rststall_eff", {31'h0, M_MemWriteEff}, 32'h0);
        RST = 0; M_Stall = 0;

        // Flush turns the instruction into a bubble but keeps data fields
        ex_idle(); EX_ALUResult = 32'h3000_0008; EX_RegWrite = 1; EX_MemWrite = 1;
        EX_ReadData2 = 32'h1111_2222; EX_RtRd = 5'd7; EX_WantRtByMEM = 1; EX_NeedRtByMEM = 1;
        EX_Flush = 1;
        step();
        chk("flush_regwr", {31'h0, M_RegWrite}, 32'h0);
        chk("flush_eff", {31'h0, M_MemWriteEff}, 32'h0);
        chk("flush_mask", {28'h0, M_WriteMask}, 32'h0);
        chk("flush_alu", M_ALUResult, 32'h3000_0008);
        chk("flush_rtrd", {27'h0, M_RtRd}, 32'd7);
        chk("flush_hazard", {30'h0, M_WantRtByMEM, M_NeedRtByMEM}, 32'h0);
        EX_Flush = 0;

        // LL then SC: success
        ex_ll(32'h0000_2000);
        step();
        chk("ll_memread", {31'h0, M_MemRead}, 32'h1);
        chk("ll_llbit_pre", {31'h0, LLBit}, 32'h0);
        ex_sc(32'h0000_2000, 32'hCAFE_F00D);
        step();
        chk("sc1_llbit", {31'h0, LLBit}, 32'h1);
        chk("sc1_eff", {31'h0, M_MemWriteEff}, 32'h1);
        chk("sc1_result", M_SCResult, 32'h1);
        chk("sc1_mask", {28'h0, M_WriteMask}, 32'hF);
        ex_idle();
        step();
        chk("sc1_llbit_post", {31'h0, LLBit}, 32'h0);

        // Second SC without a reservation fails
        ex_sc(32'h0000_2000, 32'h0BAD_0BAD);
        step();
        chk("sc2_eff", {31'h0, M_MemWriteEff}, 32'h0);
        chk("sc2_result", M_SCResult, 32'h0);
        chk("sc2_mask", {28'h0, M_WriteMask}, 32'h0);
        ex_idle();
        step();

        // LL_Clear in the same cycle an LL retires wins
        ex_ll(32'h0000_2000);
        step();
        ex_idle(); LL_Clear = 1;
        step();
        chk("llclr_race", {31'h0, LLBit}, 32'h0);
        LL_Clear = 0;

        // LL_Clear acts even while M is stalled
        ex_ll(32'h0000_2000);
        step();
        ex_idle();
        step();
        chk("ll_set", {31'h0, LLBit}, 32'h1);
        M_Stall = 1; LL_Clear = 1;
        step();
        chk("llclr_stall", {31'h0, LLBit}, 32'h0);
        M_Stall = 0; LL_Clear = 0;

        // Bubbled LL (EX stall) carries no reservation side effect
        ex_ll(32'h0000_2000); EX_Stall = 1;
        step();
        chk("bub_memread", {31'h0, M_MemRead}, 32'h0);
        chk("bub_llsc", {31'h0, M_LLSC}, 32'h1);
        EX_Stall = 0; ex_idle();
        step();
        chk("bub_llbit", {31'h0, LLBit}, 32'h0);

        // Misaligned word load
        ex_idle(); EX_ALUResult = 32'h1000_0002; EX_MemRead = 1; EX_RegWrite = 1;
        step();
        chk("lw_addrerr", {31'h0, M_AddrErr}, 32'h1);
        chk("lw_eff", {31'h0, M_MemWriteEff}, 32'h0);

        // Misaligned word store is suppressed
        ex_idle(); EX_ALUResult = 32'h1000_0002; EX_MemWrite = 1; EX_ReadData2 = 32'h1;
        step();
        chk("sw_mis_addrerr", {31'h0, M_AddrErr}, 32'h1);
        chk("sw_mis_eff", {31'h0, M_MemWriteEff}, 32'h0);
        chk("sw_mis_mask", {28'h0, M_WriteMask}, 32'h0);

        // Misaligned half load
        ex_idle(); EX_ALUResult = 32'h1000_0001; EX_MemRead = 1; EX_MemHalf = 1;
        step();
        chk("lh_mis_addrerr", {31'h0, M_AddrErr}, 32'h1);

        // Misaligned LL leaves the reservation untouched
        ex_ll(32'h0000_2002);
        step();
        chk("ll_mis_addrerr", {31'h0, M_AddrErr}, 32'h1);
        ex_idle();
        step();
        chk("ll_mis_llbit", {31'h0, LLBit}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
